// File: rtl/data_path.sv
// data_path: sixteen-entry register file feeding a combinational ALU.
// Operand A is always a register; operand B is a register or the immediate.
// The ALU result is written on the clock edge to every register whose write
// enable bit is set, and the flags are visible combinationally in the same cycle.
module data_path #(
    parameter int BIT_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 8,
    parameter int FLAG_WIDTH   = 5,
    parameter int SEL_WIDTH    = 4
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [2**SEL_WIDTH-1:0]   wEnable,
    input  logic [BIT_WIDTH-1:0]      Imm_in,
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [SEL_WIDTH-1:0]      Rdest_select,
    input  logic [SEL_WIDTH-1:0]      Rsrc_select,
    input  logic                      Imm_select,
    output logic [FLAG_WIDTH-1:0]     Flags_out
);

    localparam int NUM_REGS = 2**SEL_WIDTH;

    // Flag bit positions within Flags_out
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 3;
    localparam int FLAG_N = 4;

    // Function codes after decode
    localparam logic [3:0] FN_NOP  = 4'h0;
    localparam logic [3:0] FN_AND  = 4'h1;
    localparam logic [3:0] FN_OR   = 4'h2;
    localparam logic [3:0] FN_XOR  = 4'h3;
    localparam logic [3:0] FN_NOT  = 4'h4;
    localparam logic [3:0] FN_ADD  = 4'h5;
    localparam logic [3:0] FN_ADDU = 4'h6;
    localparam logic [3:0] FN_ADDC = 4'h7;
    localparam logic [3:0] FN_SUB  = 4'h9;
    localparam logic [3:0] FN_CMP  = 4'hB;
    localparam logic [3:0] FN_MOV  = 4'hD;

    logic [BIT_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [BIT_WIDTH-1:0]  regs_d [NUM_REGS];
    logic                  cst_q;
    logic                  cst_d;

    logic [BIT_WIDTH-1:0]  op_a;
    logic [BIT_WIDTH-1:0]  op_b;
    logic [3:0]            fn;
    logic                  is_shift;
    logic [3:0]            shamt;
    logic                  carry_in;
    logic [BIT_WIDTH:0]    sum;
    logic [BIT_WIDTH-1:0]  diff;
    logic [BIT_WIDTH-1:0]  alu_result;
    logic [FLAG_WIDTH-1:0] flags;

    assign op_a      = regs_q[Rdest_select];
    assign op_b      = Imm_select ? Imm_in : regs_q[Rsrc_select];
    assign shamt     = op_b[3:0];
    assign Flags_out = flags;

    // Opcode decode: low nibble carries the function when the high nibble is zero,
    // high nibble 8 selects the shifter, otherwise the high nibble is the function
    always_comb begin
        is_shift = 1'b0;
        fn       = opcode[7:4];
        if (opcode[7:4] == 4'h0) begin
            fn = opcode[3:0];
        end else if (opcode[7:4] == 4'h8) begin
            is_shift = 1'b1;
            fn       = FN_NOP;
        end
    end

    // ALU: result, flags and next stored carry for the current operation
    always_comb begin
        alu_result = op_a;
        flags      = '0;
        cst_d      = cst_q;
        carry_in   = (fn == FN_ADDC) ? cst_q : 1'b0;
        sum        = {1'b0, op_a} + {1'b0, op_b} + {{BIT_WIDTH{1'b0}}, carry_in};
        diff       = op_a - op_b;

        if (is_shift) begin
            case (opcode[3:0])
                4'h0, 4'h1, 4'h4: begin
                    alu_result    = op_a << shamt;
                    flags[FLAG_Z] = (alu_result == '0);
                    flags[FLAG_N] = alu_result[BIT_WIDTH-1];
                end
                4'h2, 4'h3, 4'h6: begin
                    alu_result    = $signed(op_a) >>> shamt;
                    flags[FLAG_Z] = (alu_result == '0);
                    flags[FLAG_N] = alu_result[BIT_WIDTH-1];
                end
                4'h8, 4'h9, 4'hA, 4'hB: begin
                    alu_result    = op_a >> shamt;
                    flags[FLAG_Z] = (alu_result == '0);
                    flags[FLAG_N] = alu_result[BIT_WIDTH-1];
                end
                default: begin
                    alu_result = op_a;
                    flags      = '0;
                end
            endcase
        end else begin
            case (fn)
                FN_AND, FN_OR, FN_XOR, FN_NOT, FN_MOV: begin
                    case (fn)
                        FN_AND:  alu_result = op_a & op_b;
                        FN_OR:   alu_result = op_a | op_b;
                        FN_XOR:  alu_result = op_a ^ op_b;
                        FN_NOT:  alu_result = ~op_a;
                        default: alu_result = op_b;
                    endcase
                    flags[FLAG_Z] = (alu_result == '0);
                    flags[FLAG_N] = alu_result[BIT_WIDTH-1];
                end
                FN_ADD, FN_ADDU, FN_ADDC: begin
                    alu_result    = sum[BIT_WIDTH-1:0];
                    flags[FLAG_C] = sum[BIT_WIDTH];
                    flags[FLAG_F] = (op_a[BIT_WIDTH-1] == op_b[BIT_WIDTH-1]) &&
                                    (alu_result[BIT_WIDTH-1] != op_a[BIT_WIDTH-1]);
                    flags[FLAG_Z] = (alu_result == '0);
                    flags[FLAG_N] = alu_result[BIT_WIDTH-1];
                    cst_d         = flags[FLAG_C];
                end
                FN_SUB: begin
                    alu_result    = diff;
                    flags[FLAG_C] = (op_a < op_b);
                    flags[FLAG_F] = (op_a[BIT_WIDTH-1] != op_b[BIT_WIDTH-1]) &&
                                    (alu_result[BIT_WIDTH-1] != op_a[BIT_WIDTH-1]);
                    flags[FLAG_Z] = (alu_result == '0);
                    flags[FLAG_N] = alu_result[BIT_WIDTH-1];
                    cst_d         = flags[FLAG_C];
                end
                FN_CMP: begin
                    alu_result    = op_a;
                    flags[FLAG_Z] = (op_a == op_b);
                    flags[FLAG_L] = (op_a < op_b);
                    flags[FLAG_N] = ($signed(op_a) < $signed(op_b));
                    cst_d         = 1'b0;
                end
                default: begin
                    alu_result = op_a;
                    flags      = '0;
                end
            endcase
        end
    end

    // Register write-back: every enabled register takes the same ALU result
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wEnable[i]) begin
                regs_d[i] = alu_result;
            end
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            cst_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            cst_q <= cst_d;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: scoreboard bench for data_path.
// Register contents are not ports, so they are read back through CMPI against
// the expected value (Z=1 means equal). Flags are written as {N,L,F,Z,C}.
module tb_data_path;

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        isel;
        logic [15:0] imm;
        logic [15:0] wen;
        logic [4:0]  exp;
    } step_t;

    logic        Clk;
    logic        Rst;
    logic [15:0] wEnable;
    logic [15:0] Imm_in;
    logic [7:0]  opcode;
    logic [3:0]  Rdest_select;
    logic [3:0]  Rsrc_select;
    logic        Imm_select;
    logic [4:0]  Flags_out;

    logic [4:0]  sb[$];
    int          compared;
    int          mismatched;

    data_path dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .wEnable      (wEnable),
        .Imm_in       (Imm_in),
        .opcode       (opcode),
        .Rdest_select (Rdest_select),
        .Rsrc_select  (Rsrc_select),
        .Imm_select   (Imm_select),
        .Flags_out    (Flags_out)
    );

    // Free-running clock, 10 time-unit period
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic step_t mk(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                                 input logic isel, input logic [15:0] imm, input logic [15:0] wen,
                                 input logic [4:0] exp);
        step_t s;
        s.op = op; s.a = a; s.b = b; s.isel = isel; s.imm = imm; s.wen = wen; s.exp = exp;
        return s;
    endfunction

    // Drive one operation just after a rising edge and queue its expected flags
    task automatic drive(input step_t s);
        @(posedge Clk);
        #1;
        opcode       = s.op;
        Rdest_select = s.a;
        Rsrc_select  = s.b;
        Imm_select   = s.isel;
        Imm_in       = s.imm;
        wEnable      = s.wen;
        sb.push_back(s.exp);
    endtask

    task automatic test_reset();
        step_t      steps[$];
        logic [4:0] got, exp;
        Rst = 1'b0;
        opcode = 8'h00; Rdest_select = 4'h0; Rsrc_select = 4'h0;
        Imm_select = 1'b0; Imm_in = 16'h0; wEnable = 16'hFFFF;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        wEnable = 16'h0;
        Rst = 1'b1;
        for (int i = 0; i < 16; i++) steps.push_back(mk(8'hB0, 4'(i), 4'h0, 1'b1, 16'h0000, 16'h0, 5'b00010));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge Clk);
            got = Flags_out;
            exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL reset r%0d: Flags_out=%b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_movi_add_sub();
        step_t      steps[$];
        logic [4:0] got, exp;
        steps.push_back(mk(8'hD0, 4'h0, 4'h0, 1'b1, 16'h7FFF, 16'h0001, 5'b00000));
        steps.push_back(mk(8'h0D, 4'h0, 4'h0, 1'b1, 16'h0001, 16'h0002, 5'b00000));
        steps.push_back(mk(8'hB0, 4'h0, 4'h0, 1'b1, 16'h7FFF, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'h1, 4'h0, 1'b1, 16'h0001, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'h2, 4'h0, 1'b1, 16'h0000, 16'h0000, 5'b00010));
        steps.push_back(mk(8'h05, 4'h0, 4'h1, 1'b0, 16'h0000, 16'h0004, 5'b10100));
        steps.push_back(mk(8'hB0, 4'h2, 4'h0, 1'b1, 16'h8000, 16'h0000, 5'b00010));
        steps.push_back(mk(8'h09, 4'h1, 4'h0, 1'b0, 16'h0000, 16'h0008, 5'b10001));
        steps.push_back(mk(8'h90, 4'h0, 4'h0, 1'b1, 16'h7FFF, 16'h0010, 5'b00010));
        steps.push_back(mk(8'hB0, 4'h3, 4'h0, 1'b1, 16'h8002, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'h4, 4'h0, 1'b1, 16'h0000, 16'h0000, 5'b00010));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge Clk);
            got = Flags_out;
            exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL movi_add_sub step %0d: Flags_out=%b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_cmp();
        step_t      steps[$];
        logic [4:0] got, exp;
        steps.push_back(mk(8'h0B, 4'h0, 4'h1, 1'b0, 16'h0000, 16'h0000, 5'b00000));
        steps.push_back(mk(8'hB0, 4'h4, 4'h0, 1'b1, 16'h0000, 16'h0000, 5'b00010));
        steps.push_back(mk(8'h0B, 4'h2, 4'h0, 1'b0, 16'h0000, 16'h0000, 5'b10000));
        steps.push_back(mk(8'h0B, 4'h1, 4'h2, 1'b0, 16'h0000, 16'h0000, 5'b01000));
        steps.push_back(mk(8'hB0, 4'h0, 4'h0, 1'b1, 16'h7FFF, 16'h0000, 5'b00010));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge Clk);
            got = Flags_out;
            exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL cmp step %0d: Flags_out=%b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_addc();
        step_t      steps[$];
        logic [4:0] got, exp;
        steps.push_back(mk(8'hD0, 4'h0, 4'h0, 1'b1, 16'hFFFF, 16'h0040, 5'b10000));
        steps.push_back(mk(8'hD0, 4'h0, 4'h0, 1'b1, 16'h0001, 16'h0080, 5'b00000));
        steps.push_back(mk(8'h06, 4'h6, 4'h7, 1'b0, 16'h0000, 16'h0100, 5'b00011));
        steps.push_back(mk(8'h07, 4'h8, 4'h8, 1'b0, 16'h0000, 16'h0200, 5'b00000));
        steps.push_back(mk(8'hB0, 4'h8, 4'h0, 1'b1, 16'h0000, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'h9, 4'h0, 1'b1, 16'h0001, 16'h0000, 5'b00010));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge Clk);
            got = Flags_out;
            exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL addc step %0d: Flags_out=%b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_logic();
        step_t      steps[$];
        logic [4:0] got, exp;
        steps.push_back(mk(8'h01, 4'h6, 4'h0, 1'b1, 16'h00F0, 16'h0400, 5'b00000));
        steps.push_back(mk(8'h20, 4'h0, 4'h0, 1'b1, 16'h8000, 16'h0000, 5'b10000));
        steps.push_back(mk(8'h03, 4'h6, 4'h0, 1'b1, 16'hFFFF, 16'h0000, 5'b00010));
        steps.push_back(mk(8'h04, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 5'b10000));
        steps.push_back(mk(8'h00, 4'h6, 4'h0, 1'b1, 16'h1234, 16'h0800, 5'b00000));
        steps.push_back(mk(8'h0E, 4'h6, 4'h0, 1'b1, 16'h1234, 16'h1000, 5'b00000));
        steps.push_back(mk(8'hB0, 4'hA, 4'h0, 1'b1, 16'h00F0, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'hB, 4'h0, 1'b1, 16'hFFFF, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'hC, 4'h0, 1'b1, 16'hFFFF, 16'h0000, 5'b00010));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge Clk);
            got = Flags_out;
            exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL logic step %0d: Flags_out=%b expected %b", i, got, exp);
            end
        end
    endtask

    // Shifts use r3 = 0x8002 as the operand
    task automatic test_shift();
        step_t      steps[$];
        logic [4:0] got, exp;
        steps.push_back(mk(8'h80, 4'h3, 4'h0, 1'b1, 16'h0011, 16'h0000, 5'b00000));
        steps.push_back(mk(8'h84, 4'h3, 4'h0, 1'b1, 16'h000F, 16'h0000, 5'b00010));
        steps.push_back(mk(8'h82, 4'h3, 4'h0, 1'b1, 16'h0004, 16'h0000, 5'b10000));
        steps.push_back(mk(8'h86, 4'h3, 4'h0, 1'b1, 16'h0001, 16'h0000, 5'b10000));
        steps.push_back(mk(8'h88, 4'h3, 4'h0, 1'b1, 16'h000F, 16'h0000, 5'b00000));
        steps.push_back(mk(8'h8A, 4'h3, 4'h1, 1'b0, 16'h0000, 16'h0000, 5'b00000));
        steps.push_back(mk(8'h8B, 4'h3, 4'h0, 1'b1, 16'h0010, 16'h0000, 5'b10000));
        steps.push_back(mk(8'h85, 4'h3, 4'h0, 1'b1, 16'h0001, 16'h2000, 5'b00000));
        steps.push_back(mk(8'h81, 4'h3, 4'h0, 1'b1, 16'h0001, 16'h0001, 5'b00000));
        steps.push_back(mk(8'hB0, 4'hD, 4'h0, 1'b1, 16'h8002, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'h0, 4'h0, 1'b1, 16'h0004, 16'h0000, 5'b00010));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge Clk);
            got = Flags_out;
            exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL shift step %0d: Flags_out=%b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_wenable();
        step_t      steps[$];
        logic [4:0] got, exp;
        steps.push_back(mk(8'hD0, 4'h0, 4'h0, 1'b1, 16'h0A0A, 16'h4020, 5'b00000));
        steps.push_back(mk(8'hD0, 4'h0, 4'h0, 1'b1, 16'h5555, 16'h0000, 5'b00000));
        steps.push_back(mk(8'hB0, 4'hE, 4'h0, 1'b1, 16'h0A0A, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'h5, 4'h0, 1'b1, 16'h0A0A, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'hF, 4'h0, 1'b1, 16'h0000, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hD0, 4'h0, 4'h0, 1'b1, 16'h1111, 16'h8000, 5'b00000));
        steps.push_back(mk(8'hB0, 4'hF, 4'h0, 1'b1, 16'h1111, 16'h0000, 5'b00010));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge Clk);
            got = Flags_out;
            exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL wenable step %0d: Flags_out=%b expected %b", i, got, exp);
            end
        end
    endtask

    // Set the stored carry, then pull reset low between clock edges while an
    // ADDC on r15 is presented: r15 and the carry must both clear at once
    task automatic test_reset_mid();
        step_t      steps[$];
        logic [4:0] got, exp;
        drive(mk(8'h06, 4'h6, 4'h0, 1'b1, 16'h0001, 16'h0000, 5'b00011));
        @(negedge Clk);
        got = Flags_out;
        exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL reset_mid carry set: Flags_out=%b expected %b", got, exp);
        end
        drive(mk(8'h07, 4'hF, 4'h0, 1'b1, 16'h0000, 16'h0000, 5'b00000));
        @(negedge Clk);
        got = Flags_out;
        exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL reset_mid addc before: Flags_out=%b expected %b", got, exp);
        end
        #1;
        Rst = 1'b0;
        sb.push_back(5'b00010);
        #1;
        got = Flags_out;
        exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL reset_mid async clear: Flags_out=%b expected %b", got, exp);
        end
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        steps.push_back(mk(8'hB0, 4'h0, 4'h0, 1'b1, 16'h0000, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'h6, 4'h0, 1'b1, 16'h0000, 16'h0000, 5'b00010));
        steps.push_back(mk(8'hB0, 4'hE, 4'h0, 1'b1, 16'h0000, 16'h0000, 5'b00010));
        steps.push_back(mk(8'h05, 4'h0, 4'h0, 1'b1, 16'h0003, 16'h0001, 5'b00000));
        steps.push_back(mk(8'hB0, 4'h0, 4'h0, 1'b1, 16'h0003, 16'h0000, 5'b00010));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(negedge Clk);
            got = Flags_out;
            exp = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL reset_mid resume step %0d: Flags_out=%b expected %b", i, got, exp);
            end
        end
    endtask

    // Run every scenario in order and report
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_movi_add_sub();
        test_cmp();
        test_addc();
        test_logic();
        test_shift();
        test_wenable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
